mcb_cmd_arbiter: RTL and testbench
==================================

# mcb_cmd_arbiter

Round-robin scheduler that shares the single memory-controller-block command port among NUM_REQ requesters. It sits in the clk0_bufg domain between the user-side traffic sources and the MCB command FIFO. It holds off all traffic until calibration completes and throttles on the MCB cmd_full flag. It records the owner of every issued read so returning read data can be steered to the right requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 30, byte-address width
- MAX_RD, 4, outstanding-read owner FIFO depth (power of 2)

Ports (clock, reset first):
- clk0_bufg  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- calib_done  in  1  MCB calibration complete
- req_valid  in  NUM_REQ  per-requester command pending
- req_instr  in  3*NUM_REQ  MCB instr per requester, slice i at [3i+2:3i]
- req_addr  in  ADDR_W*NUM_REQ  byte address per requester
- req_bl  in  6*NUM_REQ  burst length minus 1 per requester
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- cmd_full  in  1  MCB command FIFO full
- cmd_en  out  1  MCB command strobe
- cmd_instr  out  3  issued instr
- cmd_byte_addr  out  ADDR_W  issued address
- cmd_bl  out  6  issued burst length
- rd_done  in  1  last data beat of the oldest outstanding read consumed
- rd_owner_id  out  clog2(NUM_REQ)  owner of the oldest outstanding read
- rd_owner_valid  out  1  owner FIFO non-empty
- rd_underflow  out  1  sticky: rd_done seen with owner FIFO empty

## Operation
- A command is a read when instr[0]=1 (001, 011). All other instrs, including refresh, are non-read.
- States:
  - S_CAL: idle. Go to S_ARB when calib_done=1.
  - S_ARB:
    - If calib_done=0, go to S_CAL.
    - Otherwise search requesters starting at last_grant+1 and wrapping modulo NUM_REQ.
    - A requester is eligible when req_valid=1, and, if its command is a read, the owner count is below MAX_RD.
    - On the first eligible requester g: register its instr/addr/bl into the cmd_* holding registers, store g, go to S_ISSUE.
    - No eligible requester: stay in S_ARB.
  - S_ISSUE:
    - If cmd_full=0: assert cmd_en and req_ready[g] for one cycle. Push g into the owner FIFO if the command is a read. Set last_grant<=g. Go to S_ARB.
    - If cmd_full=1: hold cmd_* unchanged, with cmd_en=0.
    - The issue completes even if calib_done drops; S_ARB then returns to S_CAL.
- Owner FIFO:
  - rd_owner_id/rd_owner_valid show the head entry.
  - rd_done pops the head.
  - Push and pop in the same cycle leave the count unchanged. A push and pop on an empty FIFO is legal: count stays 0 and rd_owner_valid stays low.
  - rd_done on an empty FIFO with no concurrent push is ignored and sets rd_underflow, which clears only on reset.
- Requesters must hold req_valid and fields stable until req_ready. Deasserting req_valid after being latched in S_ARB does not cancel the issue.

## Timing
- Reset values:
  - State S_CAL.
  - last_grant=NUM_REQ-1, so requester 0 is first.
  - All outputs 0.
  - Owner FIFO empty.
  - rd_underflow=0.
- Reset mid-operation aborts any pending issue (no cmd_en), flushes the owner FIFO, and returns to S_CAL.
- Latency:
  - req_valid seen in S_ARB at cycle N → cmd_en at N+1 if cmd_full=0.
  - Back-to-back throughput is one command per 2 cycles.
- calib_done rising → earliest cmd_en 2 cycles later.
- cmd_en, cmd_* and req_ready are registered outputs.
- rd_owner_* update the cycle after a push or pop.
- Fairness: a continuously-valid requester is granted within NUM_REQ grants.

## Test plan
- Reset, calib_done=0, all req_valid=1 for 20 cycles → no cmd_en. Raise calib_done → first cmd_en 2 cycles later with req_ready[0], then grants 1,2,3,0 on successive issues.
- Only req 2 valid, write instr=000, addr=0x100, bl=15, cmd_full=1 for 5 cycles → cmd_en stays 0 with cmd_* held. It fires the cycle after cmd_full falls: cmd_byte_addr=0x100, cmd_bl=15, req_ready[2] pulse.
- Req 1 issues 4 reads (instr=001) with no rd_done → the 5th read from req 1 is not granted while a write from req 3 is. One rd_done → rd_owner_id=1 remains valid and the 5th read issues.
- Reads from req 0 then req 3, then two rd_done pulses → rd_owner_id sequence 0, 3, then rd_owner_valid=0. A third rd_done sets rd_underflow=1.
- rd_done coincident with a read push when the FIFO holds 1 entry → count stays 1, head advances to the new owner.
- Assert sys_rst while in S_ISSUE under cmd_full=1 → outputs 0 immediately, FIFO empty, and the first post-reset grant goes to req 0.

Source files
------------

// File: rtl/mcb_cmd_arbiter.sv
// Round-robin arbiter sharing the MCB command port among NUM_REQ requesters.
// Gates traffic on calibration, throttles on cmd_full and tracks read owners for data steering.
module mcb_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 30,
    parameter int MAX_RD  = 4
) (
    input  logic                       clk0_bufg,
    input  logic                       sys_rst,
    input  logic                       calib_done,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [3*NUM_REQ-1:0]       req_instr,
    input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
    input  logic [6*NUM_REQ-1:0]       req_bl,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cmd_full,
    output logic                       cmd_en,
    output logic [2:0]                 cmd_instr,
    output logic [ADDR_W-1:0]          cmd_byte_addr,
    output logic [5:0]                 cmd_bl,
    input  logic                       rd_done,
    output logic [$clog2(NUM_REQ)-1:0] rd_owner_id,
    output logic                       rd_owner_valid,
    output logic                       rd_underflow
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int CNT_W = $clog2(MAX_RD + 1);

    typedef enum logic [1:0] {
        S_CAL,
        S_ARB,
        S_ISSUE
    } state_t;

    state_t             state, state_nx;
    logic [ID_W-1:0]    last_grant, last_grant_nx;
    logic [ID_W-1:0]    grant, grant_nx;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               cmd_en_nx;
    logic [NUM_REQ-1:0] ready_nx;
    logic [2:0]         instr_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic [5:0]         bl_nx;
    logic               push;

    logic [2:0]         instr_arr [NUM_REQ];
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [5:0]         bl_arr    [NUM_REQ];
    logic [NUM_REQ-1:0] elig;

    logic [ID_W-1:0]    owner_mem [MAX_RD];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   rd_count;
    logic               fifo_empty, rd_full;
    logic               push_eff, pop_eff;

    assign fifo_empty = (rd_count == '0);
    assign rd_full    = (rd_count >= CNT_W'(MAX_RD));

    // A read may only be granted while the owner FIFO has room for its entry.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign instr_arr[gi] = req_instr[3*gi +: 3];
        assign addr_arr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
        assign bl_arr[gi]    = req_bl[6*gi +: 6];
        assign elig[gi]      = req_valid[gi] & ~(req_instr[3*gi] & rd_full);
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        grant_nx      = grant;
        instr_nx      = cmd_instr;
        addr_nx       = cmd_byte_addr;
        bl_nx         = cmd_bl;
        cmd_en_nx     = 1'b0;
        ready_nx      = '0;
        push          = 1'b0;
        found         = 1'b0;
        cand          = '0;
        case (state)
            S_CAL: begin
                if (calib_done) state_nx = S_ARB;
            end
            S_ARB: begin
                if (!calib_done) begin
                    state_nx = S_CAL;
                end else begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
                        if (!found && elig[cand]) begin
                            found    = 1'b1;
                            grant_nx = cand;
                            instr_nx = instr_arr[cand];
                            addr_nx  = addr_arr[cand];
                            bl_nx    = bl_arr[cand];
                            state_nx = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!cmd_full) begin
                    cmd_en_nx       = 1'b1;
                    ready_nx[grant] = 1'b1;
                    push            = cmd_instr[0];
                    last_grant_nx   = grant;
                    state_nx        = S_ARB;
                end
            end
            default: state_nx = S_CAL;
        endcase
    end

    always_ff @(posedge clk0_bufg or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= S_CAL;
            last_grant    <= ID_W'(NUM_REQ - 1);
            grant         <= '0;
            cmd_en        <= 1'b0;
            req_ready     <= '0;
            cmd_instr     <= '0;
            cmd_byte_addr <= '0;
            cmd_bl        <= '0;
        end else begin
            state         <= state_nx;
            last_grant    <= last_grant_nx;
            grant         <= grant_nx;
            cmd_en        <= cmd_en_nx;
            req_ready     <= ready_nx;
            cmd_instr     <= instr_nx;
            cmd_byte_addr <= addr_nx;
            cmd_bl        <= bl_nx;
        end
    end

    // A push and pop on an empty FIFO cancel out: the returning data belongs to the read just issued.
    assign push_eff = push & ~(rd_done & fifo_empty);
    assign pop_eff  = rd_done & ~fifo_empty;

    always_ff @(posedge clk0_bufg or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_count     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (push_eff)
                wr_ptr <= (wr_ptr == PTR_W'(MAX_RD - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_eff)
                rd_ptr <= (rd_ptr == PTR_W'(MAX_RD - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push_eff && !pop_eff)
                rd_count <= rd_count + CNT_W'(1);
            else if (!push_eff && pop_eff)
                rd_count <= rd_count - CNT_W'(1);
            if (rd_done && fifo_empty && !push)
                rd_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk0_bufg) begin
        if (push_eff) owner_mem[wr_ptr] <= grant;
    end

    assign rd_owner_valid = ~fifo_empty;
    assign rd_owner_id    = fifo_empty ? '0 : owner_mem[rd_ptr];

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Randomised and directed bench for mcb_cmd_arbiter; a transaction-level model predicts each
// issued command and the owner FIFO state, and a monitor compares them against the DUT.
module tb_mcb_cmd_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 30;
    localparam int MR  = 4;
    localparam int IDW = 2;

    logic              clk0_bufg = 1'b0;
    logic              sys_rst   = 1'b1;
    logic              calib_done = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [3*NR-1:0]   req_instr = '0;
    logic [AW*NR-1:0]  req_addr  = '0;
    logic [6*NR-1:0]   req_bl    = '0;
    logic [NR-1:0]     req_ready;
    logic              cmd_full = 1'b0;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [AW-1:0]     cmd_byte_addr;
    logic [5:0]        cmd_bl;
    logic              rd_done = 1'b0;
    logic [IDW-1:0]    rd_owner_id;
    logic              rd_owner_valid;
    logic              rd_underflow;

    mcb_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MAX_RD(MR)) dut (
        .clk0_bufg(clk0_bufg), .sys_rst(sys_rst), .calib_done(calib_done),
        .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr), .req_bl(req_bl),
        .req_ready(req_ready), .cmd_full(cmd_full), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
        .cmd_byte_addr(cmd_byte_addr), .cmd_bl(cmd_bl), .rd_done(rd_done),
        .rd_owner_id(rd_owner_id), .rd_owner_valid(rd_owner_valid), .rd_underflow(rd_underflow)
    );

    always #5 clk0_bufg = ~clk0_bufg;

    typedef struct { int cyc; int g; logic [2:0] instr; logic [AW-1:0] addr; logic [5:0] bl; } exp_t;
    typedef struct { int cyc; bit vld; int id; bit uf; } own_t;

    int   n_err = 0;
    int   n_chk = 0;
    int   edge_n = 0;
    exp_t exp_q[$];
    own_t own_q[$];
    int   grant_log[$];
    int   gedge_log[$];

    // requester agents
    bit          a_has   [NR];
    logic [2:0]  a_instr [NR];
    logic [AW-1:0] a_addr [NR];
    logic [5:0]  a_bl    [NR];

    // stimulus knobs
    int gen_pct = 0, read_pct = 0, full_mode = 0, full_pct = 0, rd_mode = 0, rd_pct = 0;
    bit k_calib = 0, calib_rand = 0, rd_pulse = 0;

    // reference model
    int         m_st;      // 0 calibrating, 1 arbitrating, 2 holding a granted command
    int         m_last, m_g;
    logic [2:0] m_instr;
    logic [AW-1:0] m_addr;
    logic [5:0] m_bl;
    int         m_own[$];
    bit         m_uf;

    always @(posedge clk0_bufg) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_last = NR - 1; m_g = 0; m_uf = 0;
        m_own.delete(); exp_q.delete(); own_q.delete();
        grant_log.delete(); gedge_log.delete();
    endtask

    task automatic model_step();
        int sz, n, i;
        bit push, found;
        sz = m_own.size(); n = edge_n + 1; push = 0; found = 0;
        case (m_st)
            0: if (calib_done) m_st = 1;
            1: begin
                if (!calib_done) m_st = 0;
                else for (int k = 1; k <= NR; k++) begin
                    i = (m_last + k) % NR;
                    if (!found && a_has[i] && !(a_instr[i][0] && sz >= MR)) begin
                        found = 1; m_g = i; m_instr = a_instr[i]; m_addr = a_addr[i]; m_bl = a_bl[i];
                        m_st = 2;
                    end
                end
            end
            default: begin
                if (!cmd_full) begin
                    exp_q.push_back('{n, m_g, m_instr, m_addr, m_bl});
                    push = m_instr[0]; m_last = m_g; a_has[m_g] = 0; m_st = 1;
                end
            end
        endcase
        if (rd_done) begin
            if (sz > 0) begin
                void'(m_own.pop_front());
                if (push) m_own.push_back(m_g);
            end else if (!push) m_uf = 1;
        end else if (push) m_own.push_back(m_g);
        own_q.push_back('{n, m_own.size() > 0, (m_own.size() > 0) ? m_own[0] : 0, m_uf});
    endtask

    task automatic post(input int i, input logic [2:0] ins, input logic [AW-1:0] ad, input logic [5:0] b);
        a_has[i] = 1; a_instr[i] = ins; a_addr[i] = ad; a_bl[i] = b;
    endtask

    task automatic drive_and_model();
        for (int i = 0; i < NR; i++)
            if (!a_has[i] && gen_pct > 0 && $urandom_range(99) < gen_pct)
                post(i, ($urandom_range(99) < read_pct) ? ($urandom_range(1) ? 3'b011 : 3'b001)
                                                        : 3'(2 * $urandom_range(3)),
                     AW'($urandom), 6'($urandom_range(63)));
        cmd_full   = (full_mode == 2) ? 1'b1 : (full_mode == 1) ? ($urandom_range(99) < full_pct) : 1'b0;
        calib_done = calib_rand ? ($urandom_range(99) >= 3) : k_calib;
        case (rd_mode)
            1:       rd_done = ($urandom_range(99) < rd_pct);
            2:       rd_done = (m_st == 2) && !cmd_full;
            default: rd_done = rd_pulse;
        endcase
        rd_pulse = 0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = a_has[i];
            req_instr[3*i +: 3]   = a_instr[i];
            req_addr[AW*i +: AW]  = a_addr[i];
            req_bl[6*i +: 6]      = a_bl[i];
        end
        model_step();
    endtask

    task automatic step();
        @(negedge clk0_bufg);
        drive_and_model();
    endtask

    task automatic settle();
        @(posedge clk0_bufg);
        #2;
    endtask

    task automatic wait_issue(input int i);
        int t = 0;
        while (a_has[i] && t < 200) begin step(); t++; end
        if (a_has[i]) begin
            n_chk++; n_err++;
            $display("FAIL wait_issue_timeout: requester %0d still pending after %0d cycles", i, t);
        end
    endtask

    task automatic reset_assert(input bit keep_agents);
        @(negedge clk0_bufg);
        sys_rst = 1'b1;
        #1;
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_instr", cmd_instr, 0);
        chk("rst_cmd_addr", cmd_byte_addr, 0);
        chk("rst_cmd_bl", cmd_bl, 0);
        chk("rst_owner_valid", rd_owner_valid, 0);
        chk("rst_owner_id", rd_owner_id, 0);
        chk("rst_underflow", rd_underflow, 0);
        m_reset();
        if (!keep_agents) for (int i = 0; i < NR; i++) a_has[i] = 0;
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk0_bufg);
        sys_rst = 1'b0;
        drive_and_model();
    endtask

    // monitor
    initial begin
        exp_t e;
        own_t o;
        int g, cnt;
        forever begin
            @(posedge clk0_bufg);
            #1;
            if (!sys_rst) begin
                if (own_q.size() > 0 && own_q[0].cyc == edge_n) begin
                    o = own_q.pop_front();
                    chk("owner_valid", rd_owner_valid, o.vld);
                    if (o.vld) chk("owner_id", rd_owner_id, o.id);
                    chk("underflow", rd_underflow, o.uf);
                end
                if (cmd_en) begin
                    g = -1; cnt = 0;
                    for (int i = 0; i < NR; i++) if (req_ready[i]) begin g = i; cnt++; end
                    if (cnt != 1) g = -1;
                    grant_log.push_back(g); gedge_log.push_back(edge_n);
                    if (exp_q.size() == 0 || exp_q[0].cyc != edge_n) begin
                        n_chk++; n_err++;
                        $display("FAIL cmd_en_timing: cmd_en at edge %0d, next expected edge %0d",
                                 edge_n, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", g, e.g);
                        chk("cmd_instr", cmd_instr, e.instr);
                        chk("cmd_addr", cmd_byte_addr, e.addr);
                        chk("cmd_bl", cmd_bl, e.bl);
                    end
                end else begin
                    chk("ready_idle", req_ready, 0);
                    if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
                        e = exp_q.pop_front();
                        n_chk++; n_err++;
                        $display("FAIL cmd_missing: no cmd_en at edge %0d, expected grant %0d", e.cyc, e.g);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cal_edge, t;
        int exp_seq [5];
        exp_seq = '{0, 1, 2, 3, 0};

        // calibration gating, then round-robin order
        reset_assert(0);
        k_calib = 0; gen_pct = 100; read_pct = 0;
        reset_release();
        repeat (20) step();
        settle();
        chk("precal_no_cmd", grant_log.size(), 0);
        k_calib = 1;
        step();
        cal_edge = edge_n + 1;
        repeat (12) step();
        settle();
        chk("cal_grant_count", grant_log.size() >= 5, 1);
        chk("cal_first_latency", (gedge_log.size() > 0) ? gedge_log[0] : -1, cal_edge + 2);
        for (int k = 0; k < 5; k++)
            chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_seq[k]);

        // cmd_full back-pressure
        gen_pct = 0;
        reset_assert(0);
        reset_release();
        full_mode = 2;
        post(2, 3'b000, 30'h100, 6'd15);
        repeat (7) step();
        settle();
        chk("full_no_issue", grant_log.size(), 0);
        chk("full_hold_addr", cmd_byte_addr, 30'h100);
        chk("full_hold_bl", cmd_bl, 15);
        full_mode = 0;
        step();
        settle();
        chk("full_release_en", cmd_en, 1);
        chk("full_release_ready", req_ready, 4'b0100);
        chk("full_release_addr", cmd_byte_addr, 30'h100);

        // outstanding-read limit
        reset_assert(0);
        reset_release();
        for (int n = 0; n < 4; n++) begin
            post(1, 3'b001, AW'(32'h200 + n * 64), 6'd7);
            wait_issue(1);
        end
        step();
        post(1, 3'b001, 30'h400, 6'd3);
        post(3, 3'b000, 30'h800, 6'd1);
        repeat (10) step();
        settle();
        chk("rdlim_grants", grant_log.size(), 5);
        chk("rdlim_write_wins", (grant_log.size() > 0) ? grant_log[$] : -1, 3);
        chk("rdlim_head", rd_owner_id, 1);
        rd_pulse = 1;
        step();
        settle();
        chk("rdlim_pop_valid", rd_owner_valid, 1);
        chk("rdlim_pop_head", rd_owner_id, 1);
        wait_issue(1);
        settle();
        chk("rdlim_fifth_read", (grant_log.size() > 0) ? grant_log[$] : -1, 1);

        // owner order and underflow
        reset_assert(0);
        reset_release();
        post(0, 3'b001, 30'h40, 6'd0);
        wait_issue(0);
        post(3, 3'b011, 30'h80, 6'd1);
        wait_issue(3);
        settle();
        chk("own_head0", rd_owner_id, 0);
        rd_pulse = 1; step(); settle();
        chk("own_head3", rd_owner_id, 3);
        chk("own_valid3", rd_owner_valid, 1);
        rd_pulse = 1; step(); settle();
        chk("own_empty", rd_owner_valid, 0);
        chk("own_no_uf", rd_underflow, 0);
        rd_pulse = 1; step(); settle();
        chk("own_underflow", rd_underflow, 1);

        // pop coincident with push at one entry
        reset_assert(0);
        reset_release();
        post(0, 3'b001, 30'h40, 6'd0);
        wait_issue(0);
        post(2, 3'b011, 30'h80, 6'd2);
        rd_mode = 2;
        wait_issue(2);
        settle();
        rd_mode = 0;
        chk("pushpop_valid", rd_owner_valid, 1);
        chk("pushpop_head", rd_owner_id, 2);
        step();

        // reset while holding a command under cmd_full
        reset_assert(0);
        reset_release();
        post(0, 3'b001, 30'h40, 6'd0);
        wait_issue(0);
        full_mode = 2;
        post(1, 3'b010, 30'h3C0, 6'd9);
        t = 0;
        while (m_st != 2 && t < 20) begin step(); t++; end
        repeat (2) step();
        reset_assert(1);
        post(0, 3'b000, 30'h10, 6'd0);
        full_mode = 0;
        reset_release();
        wait_issue(0);
        settle();
        chk("postrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        chk("postrst_fifo_empty", rd_owner_valid, 0);

        // randomized traffic
        step();
        gen_pct = 40; read_pct = 50; full_mode = 1; full_pct = 20;
        rd_mode = 1; rd_pct = 25; calib_rand = 1;
        repeat (3000) step();
        gen_pct = 0; full_mode = 0; calib_rand = 0; k_calib = 1; rd_pct = 40;
        repeat (60) step();
        settle();
        chk("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
